dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//   Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and datamem.
//   Serves 32-bit word accesses on a hit in the same cycle.
//   On a miss it stalls the CPU, writes back the dirty victim line if needed, then fills the line.
//   Both memory transfers use datamem's 128-bit line port (mem_req/mem_ready handshake).
// PARAMETERS
//   NUM_LINES  16  number of cache lines; power of 2, >=2; line = 16 bytes
//   Address split: offset [3:0], index [3+IDX:4] with IDX=$clog2(NUM_LINES), tag [31:4+IDX]
// PORTS
//   clk             in   1    single clock, all state on posedge
//   rst_n           in   1    asynchronous, active-low reset
//   cpu_req         in   1    CPU access valid this cycle
//   cpu_we          in   1    1 = store, 0 = load
//   cpu_addr        in   32   byte address; [1:0] ignored (word access)
//   cpu_wdata       in   32   store data
//   cpu_byte_en     in   4    store byte enables; bit k -> cpu_wdata[8k+7:8k]
//   cpu_rdata       out  32   load data; valid when cpu_req & !cpu_stall
//   cpu_stall       out  1    CPU must hold request; combinational
//   mem_req         out  1    line request to datamem
//   WriteEnable     out  1    1 = line writeback, 0 = line fill
//   memory_address  out  32   line-aligned address; [3:0] = 0
//   mem_writedata   out  128  victim line
//   mem_readdata    in   128  fill line
//   mem_ready       in   1    one-cycle completion pulse from datamem
// BEHAVIOUR
//   Storage:
//     - per line: valid, dirty, tag, 128-bit data
//     - reset clears all valid/dirty bits; data/tag arrays are not reset
//   Reset values:
//     - mem_req=0, WriteEnable=0, memory_address=0, mem_writedata=0, state=IDLE
//     - cpu_stall=0 while cpu_req=0
//   Byte order on the memory port (fixed, asymmetric):
//     - write: mem_writedata[8k+7:8k] = byte at line_addr+k
//     - read:  mem_readdata[127-8k:120-8k] = byte at line_addr+k
//     - the internal line is stored little-endian (byte k at [8k+7:8k]); fill data is byte-reversed on capture
//   CPU word: byte (addr&~3)+k -> cpu_rdata[8k+7:8k] (little-endian)
//   hit = cpu_req & valid[idx] & (tag[idx]==addr tag), evaluated in IDLE only
//   cpu_stall = cpu_req & (state!=IDLE | !hit)
//   FSM:
//     IDLE
//       - load hit: cpu_rdata = word addr[3:2], no state change
//       - store hit: merge enabled bytes into word addr[3:2] at the edge; set dirty
//       - miss & dirty victim -> WB_REQ; miss otherwise -> FILL_REQ
//     WB_REQ
//       - mem_req=1 for exactly 1 cycle, WriteEnable=1
//       - memory_address={victim tag,idx,4'h0}; mem_writedata=victim line
//       - -> WB_WAIT
//     WB_WAIT
//       - mem_req=0; hold address/data
//       - mem_ready=1 -> clear dirty, -> FILL_REQ
//     FILL_REQ
//       - mem_req=1 for 1 cycle, WriteEnable=0, memory_address={cpu tag,idx,4'h0}
//       - -> FILL_WAIT
//     FILL_WAIT
//       - mem_req=0
//       - mem_ready=1 -> write line, tag, valid=1, dirty=0 -> IDLE
//       - the held CPU access then hits
//   Latency with a 1-cycle memory:
//     - clean miss stalls 3 cycles; dirty miss stalls 5
//     - hit: 0 stall, load data combinational
//   Boundary conditions:
//     - mem_ready is ignored in IDLE, WB_REQ and FILL_REQ
//     - the fill address is latched at miss detection
//     - cpu_req dropped mid-miss: the miss still completes; no store merge
//     - CPU address change mid-stall is illegal (CPU holds the request)
//     - store miss: fill first, then merge on the hit cycle
//     - rst_n low in any state: immediate return to IDLE, mem_req=0, all lines invalid; dirty data is lost
// TESTING
//   1 Cold load 0x0001_0004, memory bytes 0x10000..F = 0x00..0x0F
//     -> one fill req, addr 0x0001_0000, WE=0; stall 3 cycles; cpu_rdata=0x07060504
//   2 Store 0xAABBCCDD, be=4'b0010 to 0x0001_0004 (hit), then load
//     -> no mem_req; rdata=0x0706CC04; line dirty
//   3 Load 0x0002_0004 (same idx 0)
//     -> writeback addr 0x0001_0000, mem_writedata[47:40]=0xCC; then fill 0x0002_0000; stall 5
//   4 Readback: load 0x0001_0004 after test 3 -> line refetched; rdata=0x0706CC04 (byte order round-trips)
//   5 rst_n pulsed low during FILL_WAIT
//     -> mem_req=0 at once; next load to the same address misses again
//   6 Hits on idx 1,2,3 back-to-back with spurious mem_ready in IDLE -> no stall, no state change

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and datamem.
// Hits complete in the same cycle; a miss writes back a dirty victim and then fills the line over the 128-bit port.
module dcache_ctrl #(
  parameter int unsigned NUM_LINES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  input  logic [3:0]   cpu_byte_en,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_stall,
  output logic         mem_req,
  output logic         WriteEnable,
  output logic [31:0]  memory_address,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  input  logic         mem_ready
);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 32 - 4 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_REQ,
    S_WB_WAIT,
    S_FILL_REQ,
    S_FILL_WAIT
  } state_e;

  state_e               state;
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [127:0]         data_arr [NUM_LINES];
  logic [IDX_W-1:0]     miss_idx;
  logic [TAG_W-1:0]     fill_tag;

  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic [127:0]     cur_line;
  logic [127:0]     merged_line;
  logic [127:0]     fill_line;
  logic [31:0]      cur_word;
  logic [31:0]      merged_word;
  logic             hit_c;
  logic             store_hit_c;
  logic             fill_done_c;
  logic             unused_addr_lsb;

  assign cpu_idx         = cpu_addr[4 +: IDX_W];
  assign cpu_tag         = cpu_addr[31 -: TAG_W];
  assign cur_line        = data_arr[cpu_idx];
  assign cur_word        = cur_line[{cpu_addr[3:2], 5'd0} +: 32];
  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign hit_c       = cpu_req && (state == S_IDLE) && valid_q[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
  assign store_hit_c = hit_c && cpu_we;
  assign fill_done_c = (state == S_FILL_WAIT) && mem_ready;
  assign cpu_stall   = cpu_req && ((state != S_IDLE) || !hit_c);
  assign cpu_rdata   = cur_word;

  // Store merge of the enabled bytes into the addressed word
  always_comb begin
    merged_word = cur_word;
    for (int k = 0; k < 4; k++) begin
      if (cpu_byte_en[k]) merged_word[8*k +: 8] = cpu_wdata[8*k +: 8];
    end
    merged_line = cur_line;
    merged_line[{cpu_addr[3:2], 5'd0} +: 32] = merged_word;
  end

  // Fill data arrives with byte 0 in the top byte; store the line little-endian
  always_comb begin
    fill_line = '0;
    for (int k = 0; k < 16; k++) begin
      fill_line[8*k +: 8] = mem_readdata[127-8*k -: 8];
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them
  always_ff @(posedge clk) begin
    if (fill_done_c) begin
      data_arr[miss_idx] <= fill_line;
      tag_arr[miss_idx]  <= fill_tag;
    end else if (store_hit_c) begin
      data_arr[cpu_idx] <= merged_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      mem_req        <= 1'b0;
      WriteEnable    <= 1'b0;
      memory_address <= '0;
      mem_writedata  <= '0;
      miss_idx       <= '0;
      fill_tag       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (store_hit_c) begin
            dirty_q[cpu_idx] <= 1'b1;
          end else if (cpu_req && !hit_c) begin
            miss_idx <= cpu_idx;
            fill_tag <= cpu_tag;
            mem_req  <= 1'b1;
            if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
              WriteEnable    <= 1'b1;
              memory_address <= {tag_arr[cpu_idx], cpu_idx, 4'h0};
              mem_writedata  <= cur_line;
              state          <= S_WB_REQ;
            end else begin
              WriteEnable    <= 1'b0;
              memory_address <= {cpu_tag, cpu_idx, 4'h0};
              state          <= S_FILL_REQ;
            end
          end
        end
        S_WB_REQ: begin
          mem_req <= 1'b0;
          state   <= S_WB_WAIT;
        end
        S_WB_WAIT: begin
          if (mem_ready) begin
            dirty_q[miss_idx] <= 1'b0;
            mem_req           <= 1'b1;
            WriteEnable       <= 1'b0;
            memory_address    <= {fill_tag, miss_idx, 4'h0};
            state             <= S_FILL_REQ;
          end
        end
        S_FILL_REQ: begin
          mem_req <= 1'b0;
          state   <= S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          if (mem_ready) begin
            valid_q[miss_idx] <= 1'b1;
            dirty_q[miss_idx] <= 1'b0;
            state             <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: flat-memory reference model plus abstract residency model, scoreboard queues
// checked by CPU-side and memory-side monitors, directed scenarios followed by randomized traffic.
module tb_dcache_ctrl;
  localparam int unsigned NL = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [3:0]   cpu_byte_en = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_req;
  logic         WriteEnable;
  logic [31:0]  memory_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata = '0;
  logic         mem_ready = 1'b0;

  dcache_ctrl #(.NUM_LINES(NL)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .WriteEnable(WriteEnable), .memory_address(memory_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_ready(mem_ready)
  );

  initial forever #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] addr; logic [127:0] data; } mem_exp_t;
  typedef struct { bit is_load; logic [31:0] rdata; int unsigned stall; } acc_exp_t;

  mem_exp_t    mem_q[$];
  acc_exp_t    acc_q[$];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [7:0]  dmem    [logic [31:0]];
  bit          m_valid [NL];
  bit          m_dirty [NL];
  logic [23:0] m_tag   [NL];

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned done_cnt = 0;
  int unsigned stall_cnt = 0;
  int unsigned last_stall = 0;
  logic [31:0] last_rdata = '0;
  logic [31:0] last_fill_addr = '0;
  logic [31:0] last_wb_addr = '0;
  logic [127:0] last_wb_data = '0;
  bit          hold_ready = 1'b0;
  bit          spur = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16] - 4'd1, 4'h0};
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] dmem_byte(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : init_byte(a);
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] la);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = ref_byte(la + 32'(k));
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_byte({a[31:2], 2'b00} + 32'(k));
    return w;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
  endfunction

  // Predict traffic and CPU-visible result, update the models, then drive the request
  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input bit drop);
    int unsigned idx;
    acc_exp_t    e;
    mem_exp_t    m;
    logic [31:0] va;
    idx = 32'(addr[7:4]);
    e.stall = 0;
    if (!model_hit(addr)) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        va = {m_tag[idx], addr[7:4], 4'h0};
        m.we = 1'b1; m.addr = va; m.data = ref_line(va);
        mem_q.push_back(m);
        e.stall = 5;
      end else begin
        e.stall = 3;
      end
      m.we = 1'b0; m.addr = {addr[31:4], 4'h0}; m.data = '0;
      mem_q.push_back(m);
      m_valid[idx] = 1'b1; m_tag[idx] = addr[31:8]; m_dirty[idx] = 1'b0;
    end
    if (!drop) begin
      e.is_load = !we;
      e.rdata = ref_word(addr);
      if (we) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) ref_mem[{addr[31:2], 2'b00} + 32'(k)] = wd[8*k +: 8];
        m_dirty[idx] = 1'b1;
      end
      acc_q.push_back(e);
    end
    #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_byte_en = be;
  endtask

  task automatic wait_done();
    int unsigned start;
    bit ok;
    start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (done_cnt != start) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL access_timeout: no completion after 40 cycles, required completion (addr 0x%0h)", cpu_addr);
    end
  endtask

  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    issue(we, addr, wd, be, 1'b0);
    wait_done();
  endtask

  task automatic idle(input int unsigned n);
    #1;
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom;
    repeat (n) @(posedge clk);
  endtask

  // Reset loses dirty lines: the CPU-visible memory falls back to what datamem holds
  task automatic model_reset();
    logic [31:0] la;
    for (int i = 0; i < NL; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        la = {m_tag[i], 4'(i), 4'h0};
        for (int k = 0; k < 16; k++) ref_mem[la + 32'(k)] = dmem_byte(la + 32'(k));
      end
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    acc_q.delete();
  endtask

  initial begin : cpu_mon
    acc_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || !cpu_req) begin
        stall_cnt = 0;
      end else if (cpu_stall) begin
        stall_cnt++;
      end else begin
        if (acc_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_completion: addr 0x%0h completed, required no pending access", cpu_addr);
        end else begin
          e = acc_q.pop_front();
          chk("stall_cycles", 128'(stall_cnt), 128'(e.stall));
          if (e.is_load) chk("load_rdata", cpu_rdata, e.rdata);
        end
        last_rdata = cpu_rdata;
        last_stall = stall_cnt;
        done_cnt++;
        stall_cnt = 0;
      end
    end
  end

  initial begin : mem_mon
    mem_exp_t m;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        if (mem_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_mem_req: we=%0b addr 0x%0h, required none", WriteEnable, memory_address);
        end else begin
          m = mem_q.pop_front();
          chk("mem_we", 128'(WriteEnable), 128'(m.we));
          chk("mem_addr", memory_address, m.addr);
          if (m.we) begin
            chk("mem_wdata", mem_writedata, m.data);
            last_wb_addr = memory_address;
            last_wb_data = mem_writedata;
          end else begin
            last_fill_addr = memory_address;
          end
        end
      end
    end
  end

  // datamem: one-cycle response, optional early ready while the request is still up
  initial begin : responder
    logic [31:0] a;
    bit we;
    forever begin
      @(negedge clk);
      if (spur) begin
        mem_ready = 1'b1;
      end else if (rst_n && mem_req && !hold_ready) begin
        a = memory_address;
        we = WriteEnable;
        if (we) for (int k = 0; k < 16; k++) dmem[a + 32'(k)] = mem_writedata[8*k +: 8];
        mem_ready = ($urandom_range(0, 3) == 0);
        @(posedge clk);
        #1;
        if (!we) for (int k = 0; k < 16; k++) mem_readdata[127-8*k -: 8] = dmem_byte(a + 32'(k));
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_readdata = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [23:0] tags [4];
    tags[0] = 24'h000100; tags[1] = 24'h000200; tags[2] = 24'h000301; tags[3] = 24'h12345A;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_we", 128'(WriteEnable), 128'(0));
    chk("rst_addr", memory_address, 32'h0);
    chk("rst_wdata", mem_writedata, 128'h0);
    chk("rst_stall", 128'(cpu_stall), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);

    // cold load
    do_access(1'b0, 32'h0001_0004, 32'h0, 4'h0);
    chk("t1_rdata", last_rdata, 32'h0706_0504);
    chk("t1_stall", 128'(last_stall), 128'(3));
    chk("t1_fill_addr", last_fill_addr, 32'h0001_0000);
    idle(1);

    // store hit then load back
    do_access(1'b1, 32'h0001_0004, 32'hAABB_CCDD, 4'b0010);
    do_access(1'b0, 32'h0001_0004, 32'h0, 4'h0);
    chk("t2_rdata", last_rdata, 32'h0706_CC04);
    chk("t2_stall", 128'(last_stall), 128'(0));
    idle(1);

    // conflicting load evicts the dirty line
    do_access(1'b0, 32'h0002_0004, 32'h0, 4'h0);
    chk("t3_wb_addr", last_wb_addr, 32'h0001_0000);
    chk("t3_wb_byte5", 128'(last_wb_data[47:40]), 128'(8'hCC));
    chk("t3_fill_addr", last_fill_addr, 32'h0002_0000);
    chk("t3_stall", 128'(last_stall), 128'(5));
    idle(1);

    // refetch the written-back line
    do_access(1'b0, 32'h0001_0004, 32'h0, 4'h0);
    chk("t4_rdata", last_rdata, 32'h0706_CC04);
    chk("t4_stall", 128'(last_stall), 128'(3));
    idle(1);

    // back-to-back hits on idx 1..3 with mem_ready held high
    do_access(1'b0, 32'h0001_0010, 32'h0, 4'h0);
    do_access(1'b0, 32'h0001_0020, 32'h0, 4'h0);
    do_access(1'b0, 32'h0001_0030, 32'h0, 4'h0);
    idle(1);
    spur = 1'b1;
    idle(1);
    do_access(1'b0, 32'h0001_0014, 32'h0, 4'h0);
    do_access(1'b1, 32'h0001_0028, 32'h1122_3344, 4'b1111);
    do_access(1'b0, 32'h0001_0028, 32'h0, 4'h0);
    chk("t6_rdata", last_rdata, 32'h1122_3344);
    do_access(1'b0, 32'h0001_003C, 32'h0, 4'h0);
    do_access(1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'b1001);
    do_access(1'b0, 32'h0001_0010, 32'h0, 4'h0);
    chk("t6_stall", 128'(last_stall), 128'(0));
    idle(2);
    spur = 1'b0;
    idle(2);

    // reset while waiting for the fill
    hold_ready = 1'b1;
    issue(1'b0, 32'h0003_0054, 32'h0, 4'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("t5_stall_before_rst", 128'(cpu_stall), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_mem_req", 128'(mem_req), 128'(0));
    chk("t5_addr", memory_address, 32'h0);
    cpu_req = 1'b0;
    #1;
    chk("t5_stall_idle", 128'(cpu_stall), 128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    hold_ready = 1'b0;
    @(posedge clk);
    do_access(1'b0, 32'h0003_0054, 32'h0, 4'h0);
    chk("t5_refill_stall", 128'(last_stall), 128'(3));
    chk("t5_refill_addr", last_fill_addr, 32'h0003_0050);
    idle(1);

    // randomized traffic over a small tag pool
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      bit we;
      bit drop;
      a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 4'($urandom)};
      we = 1'($urandom);
      drop = !model_hit(a) && ($urandom_range(0, 9) == 0);
      issue(we, a, $urandom, 4'($urandom), drop);
      if (drop) begin
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        repeat (6) @(posedge clk);
      end else begin
        wait_done();
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    idle(4);
    chk("acc_q_empty", 128'(acc_q.size()), 128'(0));
    chk("mem_q_empty", 128'(mem_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
